hilo_ctrl: RTL and testbench

HILO_CTRL -- requirements
Module: hilo_ctrl

---
 rtl/hilo_ctrl_if.sv | 34 +++
 rtl/hilo_ctrl.sv | 103 ++++++++++
 tb/tb_hilo_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_ctrl_if.sv
// Handshake and data bundle between the pipeline, the HI/LO controller and the multiply-divide unit.
// The slave modport is the controller's view; the master modport drives the pipeline and unit side.
interface hilo_ctrl_if;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        md_m;
    logic        md_d;
    logic [1:0]  md_op;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic [31:0] md_hi;
    logic [31:0] md_lo;
    logic        md_hiw;
    logic        md_low;
    logic        md_idle;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        err;

    modport slave (
        input  op_valid, op, rs_val, rt_val, md_hi, md_lo, md_hiw, md_low, md_idle,
        output stall, rdata, rdata_valid, md_m, md_d, md_op, md_a, md_b, hi_q, lo_q, err
    );

    modport master (
        output op_valid, op, rs_val, rt_val, md_hi, md_lo, md_hiw, md_low, md_idle,
        input  stall, rdata, rdata_valid, md_m, md_d, md_op, md_a, md_b, hi_q, lo_q, err
    );
endinterface

// File: rtl/hilo_ctrl.sv
// HI/LO register controller: mt*/mf* complete in one cycle (mf* data one cycle later); mult/div go through
// ISSUE/WAIT to the multiply-divide unit. Any instruction presented outside IDLE is stalled with no side effects.
module hilo_ctrl #(
    parameter int TIMEOUT = 32
) (
    input  logic         clk,
    input  logic         reset,
    hilo_ctrl_if.slave   hl
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ERR} state_t;

    localparam logic [7:0] LP_LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_rdata;
    logic        r_rdata_vld;
    logic [31:0] r_md_a;
    logic [31:0] r_md_b;
    logic [1:0]  r_md_op;
    logic        r_err;
    logic        w_issue_go;

    // Start pulse lives in the single ISSUE cycle where the unit reports idle.
    assign w_issue_go     = (r_state == S_ISSUE) && hl.md_idle;
    assign hl.md_m        = w_issue_go && !r_md_op[1];
    assign hl.md_d        = w_issue_go &&  r_md_op[1];
    assign hl.stall       = hl.op_valid && (r_state != S_IDLE);
    assign hl.rdata       = r_rdata;
    assign hl.rdata_valid = r_rdata_vld;
    assign hl.md_op       = r_md_op;
    assign hl.md_a        = r_md_a;
    assign hl.md_b        = r_md_b;
    assign hl.hi_q        = r_hi;
    assign hl.lo_q        = r_lo;
    assign hl.err         = r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
            r_rdata     <= 32'd0;
            r_rdata_vld <= 1'b0;
            r_md_a      <= 32'd0;
            r_md_b      <= 32'd0;
            r_md_op     <= 2'b00;
            r_err       <= 1'b0;
        end else begin
            r_rdata_vld <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (hl.op_valid) begin
                        if (!hl.op[2]) begin
                            r_md_a  <= hl.rs_val;
                            r_md_b  <= hl.rt_val;
                            r_md_op <= hl.op[1:0];
                            r_state <= S_ISSUE;
                        end else begin
                            case (hl.op[1:0])
                                2'b00:   r_hi <= hl.rs_val;
                                2'b01:   r_lo <= hl.rs_val;
                                2'b10: begin
                                    r_rdata     <= r_hi;
                                    r_rdata_vld <= 1'b1;
                                end
                                default: begin
                                    r_rdata     <= r_lo;
                                    r_rdata_vld <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                S_ISSUE: begin
                    if (hl.md_idle) begin
                        r_cnt   <= 8'd0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (hl.md_hiw) r_hi <= hl.md_hi;
                    if (hl.md_low) r_lo <= hl.md_lo;
                    // Completion wins over timeout when both land on the last counted cycle.
                    if (hl.md_hiw && hl.md_low) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == LP_LAST_WAIT) begin
                        r_state <= S_ERR;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_err <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl: mult/divu issue and capture, mt/mf paths, stall rules, timeout and reset.
module tb_hilo_ctrl;
    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   m_pulses = 0;
    int   d_pulses = 0;
    int   both_hi  = 0;

    hilo_ctrl_if hif ();

    hilo_ctrl #(.TIMEOUT(32)) dut (
        .clk   (clk),
        .reset (reset),
        .hl    (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (hif.md_m) m_pulses++;
        if (hif.md_d) d_pulses++;
        if (hif.md_m && hif.md_d) both_hi++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_op(input logic v, input logic [2:0] o, input logic [31:0] rs, input logic [31:0] rt);
        hif.op_valid = v;
        hif.op       = o;
        hif.rs_val   = rs;
        hif.rt_val   = rt;
    endtask

    task automatic drive_unit(input logic hw, input logic lw, input logic [31:0] h, input logic [31:0] l);
        hif.md_hiw = hw;
        hif.md_low = lw;
        hif.md_hi  = h;
        hif.md_lo  = l;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive_op(1'b0, 3'b000, 32'd0, 32'd0);
        drive_unit(1'b0, 1'b0, 32'd0, 32'd0);
        hif.md_idle = 1'b1;
        repeat (2) tick();
        checks++; if (hif.hi_q !== 32'd0 || hif.lo_q !== 32'd0) begin failures++; $display("FAIL reset_hilo hi=%h lo=%h exp 0/0", hif.hi_q, hif.lo_q); end
        checks++; if (hif.err !== 1'b0 || hif.rdata_valid !== 1'b0 || hif.md_op !== 2'b00) begin failures++; $display("FAIL reset_flags err=%b rv=%b md_op=%b exp 0/0/00", hif.err, hif.rdata_valid, hif.md_op); end
        reset = 1'b1;
        drive_op(1'b1, 3'b100, 32'hCAFEF00D, 32'd0);
        tick();
        drive_op(1'b0, 3'b000, 32'd0, 32'd0);
        checks++; if (hif.hi_q !== 32'hCAFEF00D) begin failures++; $display("FAIL first_edge_mthi got=%h exp=cafef00d", hif.hi_q); end
    endtask

    task automatic test_mult();
        int  mb = m_pulses;
        int  db = d_pulses;
        logic stall_ok = 1'b1;
        logic stable_ok = 1'b1;
        hif.md_idle = 1'b1;
        drive_op(1'b1, 3'b000, 32'hFFFFFFFE, 32'd3);
        #1;
        checks++; if (hif.stall !== 1'b0) begin failures++; $display("FAIL mult_accept_stall got=%b exp=0", hif.stall); end
        tick();
        drive_op(1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        checks++; if (hif.md_m !== 1'b1 || hif.md_d !== 1'b0 || hif.md_op !== 2'b00) begin failures++; $display("FAIL mult_issue m=%b d=%b op=%b exp 1/0/00", hif.md_m, hif.md_d, hif.md_op); end
        checks++; if (hif.md_a !== 32'hFFFFFFFE || hif.md_b !== 32'd3) begin failures++; $display("FAIL mult_operands a=%h b=%h exp fffffffe/3", hif.md_a, hif.md_b); end
        tick();
        drive_op(1'b1, 3'b110, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            #1;
            if (hif.stall !== 1'b1) stall_ok = 1'b0;
            if (hif.md_a !== 32'hFFFFFFFE || hif.md_b !== 32'd3 || hif.md_op !== 2'b00) stable_ok = 1'b0;
            tick();
        end
        checks++; if (stall_ok !== 1'b1) begin failures++; $display("FAIL mult_wait_stall got=%b exp=1", stall_ok); end
        checks++; if (stable_ok !== 1'b1) begin failures++; $display("FAIL mult_operand_stable got=%b exp=1", stable_ok); end
        drive_unit(1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA);
        tick();
        drive_unit(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checks++; if (hif.hi_q !== 32'hFFFFFFFF || hif.lo_q !== 32'hFFFFFFFA) begin failures++; $display("FAIL mult_result hi=%h lo=%h exp ffffffff/fffffffa", hif.hi_q, hif.lo_q); end
        checks++; if (hif.stall !== 1'b0) begin failures++; $display("FAIL mult_idle_after got stall=%b exp=0", hif.stall); end
        tick();
        drive_op(1'b0, 3'b000, 32'h0, 32'h0);
        checks++; if (hif.rdata !== 32'hFFFFFFFF || hif.rdata_valid !== 1'b1) begin failures++; $display("FAIL mult_mfhi rdata=%h rv=%b exp ffffffff/1", hif.rdata, hif.rdata_valid); end
        tick();
        checks++; if (hif.rdata_valid !== 1'b0) begin failures++; $display("FAIL mult_rv_oneshot got=%b exp=0", hif.rdata_valid); end
        checks++; if (m_pulses - mb !== 1 || d_pulses - db !== 0) begin failures++; $display("FAIL mult_pulse_count m=%0d d=%0d exp 1/0", m_pulses - mb, d_pulses - db); end
    endtask

    task automatic test_divu_busy();
        int  mb = m_pulses;
        int  db = d_pulses;
        logic hold_ok = 1'b1;
        hif.md_idle = 1'b0;
        drive_op(1'b1, 3'b011, 32'd7, 32'd2);
        tick();
        drive_op(1'b1, 3'b100, 32'hDEADBEEF, 32'd0);
        #1;
        checks++; if (hif.stall !== 1'b1) begin failures++; $display("FAIL divu_issue_stall got=%b exp=1", hif.stall); end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            if (hif.md_m !== 1'b0 || hif.md_d !== 1'b0) hold_ok = 1'b0;
        end
        checks++; if (hold_ok !== 1'b1) begin failures++; $display("FAIL divu_busy_hold got=%b exp=1", hold_ok); end
        checks++; if (hif.hi_q !== 32'hFFFFFFFF) begin failures++; $display("FAIL divu_stalled_mthi hi=%h exp=ffffffff", hif.hi_q); end
        tick();
        hif.md_idle = 1'b1;
        drive_op(1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        checks++; if (hif.md_d !== 1'b1 || hif.md_m !== 1'b0 || hif.md_op !== 2'b11) begin failures++; $display("FAIL divu_start d=%b m=%b op=%b exp 1/0/11", hif.md_d, hif.md_m, hif.md_op); end
        checks++; if (hif.md_a !== 32'd7 || hif.md_b !== 32'd2) begin failures++; $display("FAIL divu_operands a=%h b=%h exp 7/2", hif.md_a, hif.md_b); end
        tick();
        drive_unit(1'b1, 1'b0, 32'd1, 32'h0);
        tick();
        drive_unit(1'b0, 1'b1, 32'h0, 32'd3);
        drive_op(1'b1, 3'b111, 32'h0, 32'h0);
        #1;
        checks++; if (hif.hi_q !== 32'd1 || hif.lo_q !== 32'hFFFFFFFA) begin failures++; $display("FAIL divu_lone_hiw hi=%h lo=%h exp 1/fffffffa", hif.hi_q, hif.lo_q); end
        checks++; if (hif.stall !== 1'b1) begin failures++; $display("FAIL divu_still_wait stall=%b exp=1", hif.stall); end
        tick();
        checks++; if (hif.lo_q !== 32'd3 || hif.stall !== 1'b1) begin failures++; $display("FAIL divu_lone_low lo=%h stall=%b exp 3/1", hif.lo_q, hif.stall); end
        drive_unit(1'b1, 1'b1, 32'd1, 32'd3);
        tick();
        drive_unit(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checks++; if (hif.stall !== 1'b0) begin failures++; $display("FAIL divu_complete stall=%b exp=0", hif.stall); end
        tick();
        drive_op(1'b0, 3'b000, 32'h0, 32'h0);
        checks++; if (hif.rdata !== 32'd3 || hif.rdata_valid !== 1'b1 || hif.hi_q !== 32'd1) begin failures++; $display("FAIL divu_mflo rdata=%h rv=%b hi=%h exp 3/1/1", hif.rdata, hif.rdata_valid, hif.hi_q); end
        checks++; if (d_pulses - db !== 1 || m_pulses - mb !== 0) begin failures++; $display("FAIL divu_pulse_count d=%0d m=%0d exp 1/0", d_pulses - db, m_pulses - mb); end
        tick();
    endtask

    task automatic test_mthi_mfhi();
        logic stall_seen = 1'b0;
        drive_op(1'b1, 3'b100, 32'h12345678, 32'h0);
        #1;
        if (hif.stall !== 1'b0) stall_seen = 1'b1;
        tick();
        drive_op(1'b1, 3'b110, 32'h0, 32'h0);
        #1;
        if (hif.stall !== 1'b0) stall_seen = 1'b1;
        checks++; if (hif.hi_q !== 32'h12345678) begin failures++; $display("FAIL mthi_write hi=%h exp=12345678", hif.hi_q); end
        tick();
        drive_op(1'b0, 3'b000, 32'h0, 32'h0);
        checks++; if (hif.rdata !== 32'h12345678 || hif.rdata_valid !== 1'b1) begin failures++; $display("FAIL mfhi_read rdata=%h rv=%b exp 12345678/1", hif.rdata, hif.rdata_valid); end
        tick();
        checks++; if (hif.rdata_valid !== 1'b0 || stall_seen !== 1'b0) begin failures++; $display("FAIL mfhi_tail rv=%b stall_seen=%b exp 0/0", hif.rdata_valid, stall_seen); end
    endtask

    task automatic test_back_to_back();
        drive_op(1'b1, 3'b101, 32'h0BADCAFE, 32'h0);
        drive_unit(1'b1, 1'b1, 32'hAAAAAAAA, 32'h55555555);
        tick();
        drive_op(1'b1, 3'b111, 32'h0, 32'h0);
        tick();
        drive_op(1'b0, 3'b000, 32'h0, 32'h0);
        drive_unit(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (hif.rdata !== 32'h0BADCAFE || hif.rdata_valid !== 1'b1) begin failures++; $display("FAIL b2b_mflo rdata=%h rv=%b exp 0badcafe/1", hif.rdata, hif.rdata_valid); end
        checks++; if (hif.hi_q !== 32'h12345678 || hif.lo_q !== 32'h0BADCAFE) begin failures++; $display("FAIL idle_strobe_ignored hi=%h lo=%h exp 12345678/0badcafe", hif.hi_q, hif.lo_q); end
        tick();
    endtask

    task automatic test_timeout();
        int mb;
        hif.md_idle = 1'b1;
        drive_op(1'b1, 3'b010, 32'd5, 32'd0);
        tick();
        drive_op(1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        checks++; if (hif.md_d !== 1'b1 || hif.md_op !== 2'b10 || hif.md_b !== 32'd0) begin failures++; $display("FAIL div0_issue d=%b op=%b b=%h exp 1/10/0", hif.md_d, hif.md_op, hif.md_b); end
        tick();
        repeat (31) tick();
        checks++; if (hif.err !== 1'b0) begin failures++; $display("FAIL timeout_early err=%b exp=0", hif.err); end
        tick();
        checks++; if (hif.err !== 1'b1) begin failures++; $display("FAIL timeout_err err=%b exp=1", hif.err); end
        mb = m_pulses;
        drive_op(1'b1, 3'b000, 32'd1, 32'd1);
        #1;
        checks++; if (hif.stall !== 1'b1) begin failures++; $display("FAIL err_stall_hi stall=%b exp=1", hif.stall); end
        repeat (3) tick();
        checks++; if (hif.err !== 1'b1 || m_pulses - mb !== 0) begin failures++; $display("FAIL err_terminal err=%b starts=%0d exp 1/0", hif.err, m_pulses - mb); end
        drive_op(1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        checks++; if (hif.stall !== 1'b0) begin failures++; $display("FAIL err_stall_lo stall=%b exp=0", hif.stall); end
        reset = 1'b0;
        #1;
        checks++; if (hif.hi_q !== 32'd0 || hif.lo_q !== 32'd0 || hif.rdata !== 32'd0 || hif.md_a !== 32'd0 || hif.md_b !== 32'd0) begin failures++; $display("FAIL async_reset_data hi=%h lo=%h rd=%h a=%h b=%h exp all 0", hif.hi_q, hif.lo_q, hif.rdata, hif.md_a, hif.md_b); end
        checks++; if (hif.err !== 1'b0 || hif.md_op !== 2'b00 || hif.md_m !== 1'b0 || hif.md_d !== 1'b0 || hif.rdata_valid !== 1'b0) begin failures++; $display("FAIL async_reset_ctl err=%b op=%b m=%b d=%b rv=%b exp all 0", hif.err, hif.md_op, hif.md_m, hif.md_d, hif.rdata_valid); end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        hif.md_idle = 1'b1;
        drive_op(1'b1, 3'b001, 32'd3, 32'd4);
        tick();
        drive_op(1'b0, 3'b000, 32'h0, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        drive_unit(1'b1, 1'b1, 32'h55, 32'h66);
        tick();
        drive_unit(1'b0, 1'b0, 32'h0, 32'h0);
        drive_op(1'b1, 3'b111, 32'h0, 32'h0);
        #1;
        checks++; if (hif.hi_q !== 32'd0 || hif.lo_q !== 32'd0) begin failures++; $display("FAIL midwait_strobe_ignored hi=%h lo=%h exp 0/0", hif.hi_q, hif.lo_q); end
        checks++; if (hif.stall !== 1'b0) begin failures++; $display("FAIL midwait_idle stall=%b exp=0", hif.stall); end
        tick();
        drive_op(1'b0, 3'b000, 32'h0, 32'h0);
        checks++; if (hif.rdata_valid !== 1'b1 || hif.rdata !== 32'd0) begin failures++; $display("FAIL midwait_mflo rv=%b rdata=%h exp 1/0", hif.rdata_valid, hif.rdata); end
        tick();
    endtask

    initial begin
        test_reset();
        test_mult();
        test_divu_busy();
        test_mthi_mfhi();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        checks++; if (both_hi !== 0) begin failures++; $display("FAIL start_exclusive overlaps=%0d exp=0", both_hi); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
